// File: rtl/mypack.sv
// Shared definitions for the fetch stage: FSM state encoding and the reset NOP word.
package mypack;
    typedef enum logic [1:0] {FS_REQ, FS_WAIT, FS_VALID} fState;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction RAM port, instruction handshake and redirect.
interface instr_fetch_unit_if;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    // master is the fetch unit, slave is the RAM/control-unit side
    modport master (
        output mem_addr, mem_re, instr, instr_pc, instr_valid,
        input  mem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  mem_addr, mem_re, instr, instr_pc, instr_valid,
        output mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: owns the PC, reads the synchronous instruction RAM,
// and hands the captured word to the control unit over a valid/ready handshake.
module instr_fetch_unit
    import mypack::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          RAM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_unit_if.master bus
);

    localparam logic [2:0] WAIT_INIT = 3'(RAM_LATENCY - 1);

    fState       state;
    logic [31:0] pc;
    logic [2:0]  wait_cnt;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FS_REQ;
            pc            <= RESET_PC;
            wait_cnt      <= 3'd0;
            instr_q       <= RV_NOP;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else if (bus.redirect) begin
            // redirect wins everywhere, including a same-cycle handshake
            pc            <= {bus.redirect_pc[31:2], 2'b00};
            state         <= FS_REQ;
            wait_cnt      <= 3'd0;
            instr_valid_q <= 1'b0;
        end else begin
            case (state)
                FS_REQ: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        instr_q       <= bus.mem_rdata;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        state         <= FS_VALID;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                FS_VALID: begin
                    if (bus.instr_ready) begin
                        pc            <= pc + 32'd4;
                        instr_valid_q <= 1'b0;
                        state         <= FS_REQ;
                    end
                end
                default: state <= FS_REQ;
            endcase
        end
    end

    // The read address is simply the PC; mem_re is gated by rst_n so it drops with the async reset.
    assign bus.mem_addr    = pc;
    assign bus.mem_re      = rst_n && (state != FS_VALID);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a latency-2 unit driven by a vector table and hand sequences,
// plus a latency-1 unit resetting to FFFF_FFFC with ready tied high to check PC wrap.
module tb_instr_fetch_unit;
    import mypack::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus0();
    instr_fetch_unit_if bus1();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .RAM_LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .RAM_LATENCY(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    function automatic logic [31:0] ram_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a ^ 32'h5A5A_0000) + 32'h13;
    endfunction

    // RAM models: address registered, then output register (latency 2) or just one stage (latency 1)
    logic [31:0] p0a, p0b, p1a;
    always_ff @(posedge clk) begin
        p0a <= bus0.mem_addr;
        p0b <= p0a;
        p1a <= bus1.mem_addr;
    end
    assign bus0.mem_rdata = ram_f(p0b);
    assign bus1.mem_rdata = ram_f(p1a);

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        redir;
        logic [31:0] target;
        int          stall;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (bus0.instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("valid_within_budget", {31'd0, bus0.instr_valid}, 32'd1);
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = ram_f(pc);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({name, "_instr"}, bus0.instr, e.instr);
            chk({name, "_pc"}, bus0.instr_pc, e.pc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t cur;
        logic [31:0] nxt;

        vecs[0] = '{redir: 1'b0, target: 32'h0,         stall: 0};
        vecs[1] = '{redir: 1'b0, target: 32'h0,         stall: 10};
        vecs[2] = '{redir: 1'b1, target: 32'h0000_0040, stall: 0};
        vecs[3] = '{redir: 1'b1, target: 32'h0000_1003, stall: 3};
        vecs[4] = '{redir: 1'b0, target: 32'h0,         stall: 1};

        bus0.instr_ready = 1'b0; bus0.redirect = 1'b0; bus0.redirect_pc = 32'h0;
        bus1.instr_ready = 1'b1; bus1.redirect = 1'b0; bus1.redirect_pc = 32'h0;

        tick(); tick();
        chk("rst_mem_re", {31'd0, bus0.mem_re}, 32'd0);
        chk("rst_valid", {31'd0, bus0.instr_valid}, 32'd0);
        chk("rst_instr", bus0.instr, RV_NOP);
        chk("rst_instr_pc", bus0.instr_pc, 32'h0);
        chk("rst_mem_addr", bus0.mem_addr, 32'h0);
        chk("rst_wrap_addr", bus1.mem_addr, 32'hFFFF_FFFC);

        // cycle 0: first request; ready high early must be ignored while not valid
        rst_n = 1'b1;
        bus0.instr_ready = 1'b1;
        #1;
        chk("c0_mem_addr", bus0.mem_addr, 32'h0);
        chk("c0_mem_re", {31'd0, bus0.mem_re}, 32'd1);
        chk("c0_wrap_addr", bus1.mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("c1_valid", {31'd0, bus0.instr_valid}, 32'd0);
        tick();
        chk("c2_valid", {31'd0, bus0.instr_valid}, 32'd0);
        chk("c2_wrap_valid", {31'd0, bus1.instr_valid}, 32'd1);
        chk("c2_wrap_pc", bus1.instr_pc, 32'hFFFF_FFFC);
        chk("c2_wrap_instr", bus1.instr, ram_f(32'hFFFF_FFFC));
        tick();
        chk("c3_valid", {31'd0, bus0.instr_valid}, 32'd1);
        chk("c3_instr", bus0.instr, 32'h0050_0093);
        chk("c3_instr_pc", bus0.instr_pc, 32'h0);
        chk("c3_wrap_addr", bus1.mem_addr, 32'h0);
        chk("c3_wrap_re", {31'd0, bus1.mem_re}, 32'd1);
        tick();
        bus0.instr_ready = 1'b0;
        chk("c4_mem_addr", bus0.mem_addr, 32'h4);
        chk("c4_mem_re", {31'd0, bus0.mem_re}, 32'd1);
        chk("c4_valid", {31'd0, bus0.instr_valid}, 32'd0);
        push_exp(32'h4);

        foreach (vecs[i]) begin
            wait_valid();
            cur = sb.size() != 0 ? sb[0] : '{pc: 32'hx, instr: 32'hx};
            pop_check($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_re_low", i), {31'd0, bus0.mem_re}, 32'd0);
            for (int s = 0; s < vecs[i].stall; s++) begin
                tick();
                chk($sformatf("vec%0d_hold_instr", i), bus0.instr, cur.instr);
                chk($sformatf("vec%0d_hold_pc", i), bus0.instr_pc, cur.pc);
                chk($sformatf("vec%0d_hold_re", i), {31'd0, bus0.mem_re}, 32'd0);
                chk($sformatf("vec%0d_hold_addr", i), bus0.mem_addr, cur.pc);
            end
            bus0.instr_ready = 1'b1;
            bus0.redirect = vecs[i].redir;
            bus0.redirect_pc = vecs[i].target;
            tick();
            bus0.instr_ready = 1'b0;
            bus0.redirect = 1'b0;
            nxt = vecs[i].redir ? {vecs[i].target[31:2], 2'b00} : cur.pc + 32'd4;
            chk($sformatf("vec%0d_next_addr", i), bus0.mem_addr, nxt);
            chk($sformatf("vec%0d_next_re", i), {31'd0, bus0.mem_re}, 32'd1);
            chk($sformatf("vec%0d_next_valid", i), {31'd0, bus0.instr_valid}, 32'd0);
            push_exp(nxt);
        end

        // redirect while the read is in flight: stale word must never be captured
        tick();
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 32'h0000_0103;
        tick();
        bus0.redirect = 1'b0;
        sb.delete();
        push_exp(32'h0000_0100);
        chk("wait_redir_addr", bus0.mem_addr, 32'h0000_0100);
        chk("wait_redir_re", {31'd0, bus0.mem_re}, 32'd1);
        chk("wait_redir_valid", {31'd0, bus0.instr_valid}, 32'd0);
        wait_valid();
        pop_check("wait_redir");

        // async reset in the middle of a read
        bus0.instr_ready = 1'b1;
        tick();
        bus0.instr_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus0.instr_valid}, 32'd0);
        chk("arst_instr", bus0.instr, RV_NOP);
        chk("arst_re", {31'd0, bus0.mem_re}, 32'd0);
        chk("arst_addr", bus0.mem_addr, 32'h0);
        chk("arst_instr_pc", bus0.instr_pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rr_c0_addr", bus0.mem_addr, 32'h0);
        chk("rr_c0_re", {31'd0, bus0.mem_re}, 32'd1);
        push_exp(32'h0);
        tick(); tick();
        chk("rr_c2_valid", {31'd0, bus0.instr_valid}, 32'd0);
        tick();
        chk("rr_c3_valid", {31'd0, bus0.instr_valid}, 32'd1);
        pop_check("rr_c3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
